// File: rtl/lfsr_run_ctrl_pkg.sv
// Shared definitions for the LFSR run controller: FSM encodings, the lock-up seed value
// and the default widths.
package lfsr_run_ctrl_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  // An all-zero seed locks an XOR-feedback LFSR, so such jobs are rejected.
  localparam int ZERO_SEED = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/lfsr_step_counter.sv
// Step counter for the LFSR run controller: clear, count enable and a terminal flag
// that marks the last step of the job (cnt == steps - 1).
module lfsr_step_counter
  import lfsr_run_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_steps,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_term
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_term = (r_cnt == i_steps - CNT_W'(1));

endmodule

// File: rtl/lfsr_run_ctrl.sv
// Job sequencer that owns seed/sel of one 4-bit LFSR: load, step N times, freeze, report.
// Optional build macro LFSR_PERIOD_DETECT_EN stops a job early when the state returns to the seed.
module lfsr_run_ctrl
  import lfsr_run_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_seed,
  input  logic [CNT_W-1:0] req_steps,
  output logic [WIDTH-1:0] lfsr_seed,
  output logic             lfsr_sel,
  input  logic [WIDTH-1:0] lfsr_state,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] done_state,
  output logic [CNT_W-1:0] done_steps,
  output logic             done_err,
  output logic             done_hit,
  output logic             busy
);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_seed;
  logic [CNT_W-1:0] r_steps;
  logic             r_err;
  logic             r_hit;
  logic [CNT_W-1:0] w_cnt;
  logic             w_term;
  logic             w_accept;
  logic             w_zero;
  logic             w_hit;
  logic             w_cnt_clr;
  logic             w_cnt_en;

  assign w_accept = req_valid && (r_state == ST_IDLE);
  assign w_zero   = (req_seed == WIDTH'(ZERO_SEED));

`ifdef LFSR_PERIOD_DETECT_EN
  // Returning to the seed after at least one step means a full period has elapsed.
  assign w_hit = (r_state == ST_RUN) && (w_cnt != '0) && (lfsr_state == r_seed);
`else
  assign w_hit = 1'b0;
`endif

  lfsr_step_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .i_steps (r_steps),
    .o_cnt   (w_cnt),
    .o_term  (w_term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = w_zero ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_next = (r_steps == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (w_hit || w_term) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (done_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Outside LOAD/RUN the LFSR reloads its own state, which freezes it.
  always_comb begin
    req_ready  = (r_state == ST_IDLE);
    busy       = (r_state != ST_IDLE);
    done_valid = (r_state == ST_DONE);
    lfsr_sel   = (r_state != ST_RUN) || w_hit;
    lfsr_seed  = (r_state == ST_LOAD) ? r_seed : lfsr_state;
    w_cnt_clr  = w_accept || (r_state == ST_LOAD);
    w_cnt_en   = (r_state == ST_RUN) && !w_hit;
    done_state = ((r_state == ST_DONE) && !r_err) ? lfsr_state : '0;
    done_steps = w_cnt;
    done_err   = r_err;
    done_hit   = r_hit;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_seed  <= req_seed;
      r_steps <= req_steps;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
      r_hit <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_zero;
      r_hit <= 1'b0;
    end else if (w_hit) begin
      r_hit <= 1'b1;
    end else if ((r_state == ST_DONE) && done_ready) begin
      r_err <= 1'b0;
      r_hit <= 1'b0;
    end
  end

endmodule
